// File: rtl/console_rx_fifo.sv
// Console receive buffer: a DEPTH-entry first-word-fall-through FIFO fed by a
// four-phase valid/ack producer, with backpressure or drop-on-full behaviour.
module console_rx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    localparam int ADDR_W    = $clog2(DEPTH)
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [DATA_WIDTH-1:0] IN_DATA,
    input  logic                  IN_VALID,
    output logic                  IN_ACK,
    input  logic                  DROP_WHEN_FULL,
    input  logic                  RD_EN,
    output logic [DATA_WIDTH-1:0] RD_DATA,
    output logic                  EMPTY,
    output logic                  FULL,
    output logic [ADDR_W:0]       COUNT,
    output logic                  OVERFLOW,
    input  logic                  OVF_CLR
);

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_W-1:0]     wp;
    logic [ADDR_W-1:0]     rp;
    logic [ADDR_W:0]       count;
    logic                  armed;
    logic                  ack_q;
    logic                  ovf_q;

    logic capture;
    logic store;
    logic pop;

    // Status comes only from the registered count, so EMPTY/FULL never
    // depend combinationally on IN_VALID or RD_EN.
    assign EMPTY    = (count == '0);
    assign FULL     = (count == FULL_COUNT);
    assign COUNT    = count;
    assign IN_ACK   = ack_q;
    assign OVERFLOW = ovf_q;
    assign RD_DATA  = EMPTY ? '0 : mem[rp];

    // NOTE: every signal written here gets a value on every path through the
    // block; a missing assignment would infer a latch.
    always_comb begin
        capture = IN_VALID && armed && (!FULL || DROP_WHEN_FULL);
        store   = capture && !FULL;
        pop     = RD_EN && !EMPTY;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
            armed <= 1'b1;
            ack_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            ack_q <= capture;

            // One capture per request: re-arm only once the producer drops valid.
            if (!IN_VALID) begin
                armed <= 1'b1;
            end else if (capture) begin
                armed <= 1'b0;
            end

            if (store) begin
                wp <= wp + 1'b1;
            end
            if (pop) begin
                rp <= rp + 1'b1;
            end

            case ({store, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            // A drop on the same edge as a clear keeps the flag set.
            if (capture && FULL) begin
                ovf_q <= 1'b1;
            end else if (OVF_CLR) begin
                ovf_q <= 1'b0;
            end
        end
    end

    // NOTE: the storage array has no reset; stale entries are unreachable
    // because the pointers and count are reset.
    always_ff @(posedge CLK) begin
        if (store && !RESET) begin
            mem[wp] <= IN_DATA;
        end
    end

endmodule

// File: tb/tb_console_rx_fifo.sv
// Self-checking bench for console_rx_fifo: queue-based reference model with a
// decoupled read-data scoreboard, directed scenarios and a randomized phase.
module tb_console_rx_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);

    logic          CLK = 1'b0;
    logic          RESET;
    logic [DW-1:0] IN_DATA;
    logic          IN_VALID;
    logic          IN_ACK;
    logic          DROP_WHEN_FULL;
    logic          RD_EN;
    logic [DW-1:0] RD_DATA;
    logic          EMPTY;
    logic          FULL;
    logic [AW:0]   COUNT;
    logic          OVERFLOW;
    logic          OVF_CLR;

    console_rx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .IN_DATA        (IN_DATA),
        .IN_VALID       (IN_VALID),
        .IN_ACK         (IN_ACK),
        .DROP_WHEN_FULL (DROP_WHEN_FULL),
        .RD_EN          (RD_EN),
        .RD_DATA        (RD_DATA),
        .EMPTY          (EMPTY),
        .FULL           (FULL),
        .COUNT          (COUNT),
        .OVERFLOW       (OVERFLOW),
        .OVF_CLR        (OVF_CLR)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    // Reference model: the FIFO is a plain queue of bytes.
    bit            model_on = 1'b0;
    logic [DW-1:0] mq[$];
    logic [DW-1:0] exp_rd_q[$];
    bit            served;
    bit            exp_ack;
    bit            exp_ovf;
    bit            m_full;
    bit            m_take;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h time=%0t", name, act, exp, $time);
        end
    endtask

    // At each falling edge: compare observable state, then apply the coming rising edge.
    always @(negedge CLK) begin
        if (model_on) begin
            check("count",    32'(COUNT),    32'(mq.size()));
            check("empty",    32'(EMPTY),    32'(mq.size() == 0));
            check("full",     32'(FULL),     32'(mq.size() == DEPTH));
            check("overflow", 32'(OVERFLOW), 32'(exp_ovf));
            check("in_ack",   32'(IN_ACK),   32'(exp_ack));
            if (mq.size() == 0) check("rd_data_when_empty", 32'(RD_DATA), 32'(0));
        end
        if (RESET) begin
            mq.delete();
            served   = 1'b0;
            exp_ack  = 1'b0;
            exp_ovf  = 1'b0;
            model_on = 1'b1;
        end else if (model_on) begin
            m_full = (mq.size() == DEPTH);
            m_take = IN_VALID && !served && (!m_full || DROP_WHEN_FULL);
            if (RD_EN && mq.size() > 0) exp_rd_q.push_back(mq.pop_front());
            if (m_take && !m_full) mq.push_back(IN_DATA);
            if (m_take && m_full) exp_ovf = 1'b1;
            else if (OVF_CLR)     exp_ovf = 1'b0;
            exp_ack = m_take;
            served  = IN_VALID ? (served || m_take) : 1'b0;
        end
    end

    // Read-data monitor: whenever the DUT presents a pop, compare the head byte.
    always begin
        @(negedge CLK);
        #1;
        if (model_on && !RESET && RD_EN && !EMPTY) begin
            if (exp_rd_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rd_unexpected actual=0x%0h expected=no_pop time=%0t", RD_DATA, $time);
            end else begin
                check("rd_data", 32'(RD_DATA), 32'(exp_rd_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_ack(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (IN_ACK) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL %s actual=no_ack required=ack_within_40_cycles", name);
        end
    endtask

    task automatic send(input logic [DW-1:0] b);
        IN_DATA  = b;
        IN_VALID = 1'b1;
        wait_ack("send_ack_timeout");
        IN_VALID = 1'b0;
        tick();
    endtask

    task automatic pop_n(input int n);
        RD_EN = 1'b1;
        repeat (n) tick();
        RD_EN = 1'b0;
    endtask

    int  acks;
    bit  acked;
    int  rd_pct;

    initial begin
        RESET = 1'b1; IN_DATA = '0; IN_VALID = 1'b0; DROP_WHEN_FULL = 1'b0;
        RD_EN = 1'b0; OVF_CLR = 1'b0;
        tick(); tick();
        RESET = 1'b0;
        check("reset_count", 32'(COUNT), 32'(0));
        check("reset_empty", 32'(EMPTY), 32'(1));

        // Basic capture: valid held 10 cycles, exactly one ack.
        acks = 0;
        IN_DATA = 8'h50; IN_VALID = 1'b1;
        repeat (10) begin
            tick();
            if (IN_ACK) acks++;
        end
        IN_VALID = 1'b0;
        tick();
        check("basic_ack_pulses", 32'(acks), 32'(1));
        check("basic_head", 32'(RD_DATA), 32'(8'h50));
        pop_n(1);
        check("basic_empty_after_pop", 32'(EMPTY), 32'(1));

        // Ordering and pointer wrap.
        send(8'h50); send(8'h41); send(8'h0D);
        pop_n(3);
        for (int i = 0; i < 2 * DEPTH; i++) begin
            send(8'(i + 8'h60));
            if (i % 3 == 2) pop_n(3);
        end
        pop_n(DEPTH);

        // Backpressure: full FIFO holds off a waiting request until a pop.
        DROP_WHEN_FULL = 1'b0;
        for (int i = 0; i < DEPTH; i++) send(8'(i));
        IN_DATA = 8'hAA; IN_VALID = 1'b1;
        repeat (4) tick();
        check("bp_full", 32'(FULL), 32'(1));
        check("bp_no_ack", 32'(IN_ACK), 32'(0));
        pop_n(1);
        check("bp_no_ack_on_pop_edge", 32'(IN_ACK), 32'(0));
        tick();
        check("bp_ack_after_pop", 32'(IN_ACK), 32'(1));
        IN_VALID = 1'b0;
        tick();
        pop_n(DEPTH);
        check("bp_overflow_clear", 32'(OVERFLOW), 32'(0));

        // Drop mode: full FIFO acks and discards, overflow is sticky.
        for (int i = 0; i < DEPTH; i++) send(8'($urandom));
        DROP_WHEN_FULL = 1'b1;
        send(8'hBB);
        check("drop_count", 32'(COUNT), 32'(DEPTH));
        check("drop_overflow", 32'(OVERFLOW), 32'(1));
        OVF_CLR = 1'b1; IN_DATA = 8'hCC; IN_VALID = 1'b1;
        tick();
        OVF_CLR = 1'b0;
        check("drop_beats_clear", 32'(OVERFLOW), 32'(1));
        IN_VALID = 1'b0;
        tick();
        OVF_CLR = 1'b1;
        tick();
        OVF_CLR = 1'b0;
        check("lone_clear", 32'(OVERFLOW), 32'(0));
        pop_n(DEPTH);
        DROP_WHEN_FULL = 1'b0;

        // Simultaneous capture and pop with five entries stored.
        for (int i = 0; i < 5; i++) send(8'(8'h20 + i));
        IN_DATA = 8'h77; IN_VALID = 1'b1; RD_EN = 1'b1;
        tick();
        RD_EN = 1'b0;
        check("simul_count", 32'(COUNT), 32'(5));
        check("simul_head", 32'(RD_DATA), 32'(8'h21));
        IN_VALID = 1'b0;
        tick();
        pop_n(5);
        pop_n(3);
        check("underflow_count", 32'(COUNT), 32'(0));

        // Reset while a request is held with three bytes stored.
        send(8'h01); send(8'h02); send(8'h03);
        IN_DATA = 8'h5A; IN_VALID = 1'b1; RESET = 1'b1;
        tick();
        check("midreset_count", 32'(COUNT), 32'(0));
        check("midreset_ack", 32'(IN_ACK), 32'(0));
        RESET = 1'b0;
        tick();
        check("postreset_ack", 32'(IN_ACK), 32'(1));
        check("postreset_count", 32'(COUNT), 32'(1));
        IN_VALID = 1'b0;
        tick();
        pop_n(1);

        // Randomized traffic against the reference model.
        acked  = 1'b0;
        rd_pct = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 500 == 0) rd_pct = $urandom_range(80, 10);
            if (IN_VALID) begin
                if (IN_ACK) acked = 1'b1;
                if (acked && $urandom_range(3) != 0) begin
                    IN_VALID = 1'b0;
                    acked    = 1'b0;
                end
            end else if ($urandom_range(2) == 0) begin
                IN_DATA  = 8'($urandom);
                IN_VALID = 1'b1;
            end
            RD_EN   = ($urandom_range(99) < rd_pct);
            OVF_CLR = ($urandom_range(15) == 0);
            RESET   = ($urandom_range(399) == 0);
            if ($urandom_range(49) == 0) DROP_WHEN_FULL = ~DROP_WHEN_FULL;
            tick();
        end

        IN_VALID = 1'b0; RESET = 1'b0; OVF_CLR = 1'b0; DROP_WHEN_FULL = 1'b0;
        tick();
        pop_n(DEPTH + 2);
        tick(); tick();
        check("scoreboard_drained", 32'(exp_rd_q.size()), 32'(0));
        check("final_empty", 32'(EMPTY), 32'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
